// File: rtl/imm_pack.sv
// Immediate packer: scatters an immediate into RV32I field positions of an instruction template,
// flags unrepresentable immediates, and buffers {inst, err} in a small FIFO behind valid/ready.
module imm_pack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       in_imm_type_i,
    input  logic [31:0]      in_imm_i,
    input  logic [31:0]      in_base_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_inst_o,
    output logic             out_err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [2:0] ITYPE = 3'd0;
    localparam logic [2:0] STYPE = 3'd1;
    localparam logic [2:0] BTYPE = 3'd2;
    localparam logic [2:0] UTYPE = 3'd3;
    localparam logic [2:0] JTYPE = 3'd4;

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [31:0]      inst_mem_q [DEPTH];
    logic             err_mem_q  [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [31:0] pack_inst;
    logic        pack_err;
    logic        push, pop;

    // Packing and range check; truncated bits are still packed when the range check fails.
    always_comb begin
        pack_inst = in_base_i;
        pack_err  = 1'b0;
        unique case (in_imm_type_i)
            ITYPE: begin
                pack_inst[31:20] = in_imm_i[11:0];
                pack_err = ~((&in_imm_i[31:11]) | ~(|in_imm_i[31:11]));
            end
            STYPE: begin
                pack_inst[31:25] = in_imm_i[11:5];
                pack_inst[11:7]  = in_imm_i[4:0];
                pack_err = ~((&in_imm_i[31:11]) | ~(|in_imm_i[31:11]));
            end
            BTYPE: begin
                pack_inst[31]    = in_imm_i[12];
                pack_inst[30:25] = in_imm_i[10:5];
                pack_inst[11:8]  = in_imm_i[4:1];
                pack_inst[7]     = in_imm_i[11];
                pack_err = ~((&in_imm_i[31:12]) | ~(|in_imm_i[31:12])) | in_imm_i[0];
            end
            UTYPE: begin
                pack_inst[31:12] = in_imm_i[31:12];
                pack_err = |in_imm_i[11:0];
            end
            JTYPE: begin
                pack_inst[31]    = in_imm_i[20];
                pack_inst[30:21] = in_imm_i[10:1];
                pack_inst[20]    = in_imm_i[11];
                pack_inst[19:12] = in_imm_i[19:12];
                pack_err = ~((&in_imm_i[31:20]) | ~(|in_imm_i[31:20])) | in_imm_i[0];
            end
            default: pack_err = 1'b1;
        endcase
    end

    assign in_ready_o  = (count_q != FullCnt);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign out_inst_o  = inst_mem_q[rptr_q];
    assign out_err_o   = err_mem_q[rptr_q];
    assign err_cnt_o   = err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                err_mem_q[i]  <= 1'b0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            if (push) begin
                inst_mem_q[wptr_q] <= pack_inst;
                err_mem_q[wptr_q]  <= pack_err;
                wptr_q             <= wptr_q + 1'b1;
                if (pack_err && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_pack.sv
// Directed bench for imm_pack: fixed packing vectors, backpressure, concurrent push/pop, reset.
module tb_imm_pack;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] ITYPE = 3'd0;
    localparam logic [2:0] STYPE = 3'd1;
    localparam logic [2:0] BTYPE = 3'd2;
    localparam logic [2:0] UTYPE = 3'd3;
    localparam logic [2:0] JTYPE = 3'd4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_imm_type;
    logic [31:0]      in_imm;
    logic [31:0]      in_base;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    logic [2:0]  exp_type;
    logic [31:0] exp_imm;
    logic [31:0] exp_base;
    logic [31:0] r;

    imm_pack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_imm_type_i (in_imm_type),
        .in_imm_i      (in_imm),
        .in_base_i     (in_base),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_inst_o    (out_inst),
        .out_err_o     (out_err),
        .err_cnt_o     (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
        in_valid    = 1'b1;
        in_imm_type = t;
        in_imm      = imm;
        in_base     = base;
    endtask

    // Reference immediate extender (decode side).
    function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] i);
        case (t)
            ITYPE:   return {{20{i[31]}}, i[31:20]};
            STYPE:   return {{20{i[31]}}, i[31:25], i[11:7]};
            BTYPE:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            UTYPE:   return {i[31:12], 12'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_imm_type = ITYPE; in_imm = '0; in_base = '0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_inst",  out_inst,       32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        #6 rst = 1'b0;

        // Back-to-back directed packing vectors, consumer always ready.
        drive(ITYPE, 32'hFFFF_FFFF, 32'h0000_0013); step();
        chk("i_valid", 32'(out_valid), 32'd1);
        chk("i_inst",  out_inst, 32'hFFF0_0013);
        chk("i_err",   32'(out_err), 32'd0);
        chk("i_cnt",   32'(err_cnt), 32'd0);
        drive(BTYPE, 32'h0000_0800, 32'h0000_0063); step();
        chk("b_inst",  out_inst, 32'h0000_00E3);
        chk("b_err",   32'(out_err), 32'd0);
        drive(BTYPE, 32'h0000_1000, 32'h0000_0063); step();
        chk("b_ovf_inst", out_inst, 32'h8000_0063);
        chk("b_ovf_err",  32'(out_err), 32'd1);
        chk("b_ovf_cnt",  32'(err_cnt), 32'd1);
        drive(JTYPE, 32'h0000_0003, 32'h0000_006F); step();
        chk("j_odd_inst", out_inst, 32'h0020_006F);
        chk("j_odd_err",  32'(out_err), 32'd1);
        chk("j_odd_cnt",  32'(err_cnt), 32'd2);
        drive(UTYPE, 32'h0000_1001, 32'h0000_0037); step();
        chk("u_low_inst", out_inst, 32'h0000_1037);
        chk("u_low_err",  32'(out_err), 32'd1);
        chk("u_low_cnt",  32'(err_cnt), 32'd3);
        drive(STYPE, 32'hFFFF_F800, 32'h0000_2023); step();
        chk("s_inst", out_inst, 32'h8000_2023);
        chk("s_err",  32'(out_err), 32'd0);
        chk("s_cnt",  32'(err_cnt), 32'd3);
        drive(3'd7, 32'h0000_0005, 32'h1234_5677); step();
        chk("bad_type_inst", out_inst, 32'h1234_5677);
        chk("bad_type_err",  32'(out_err), 32'd1);
        chk("bad_type_cnt",  32'(err_cnt), 32'd4);
        in_valid = 1'b0; step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: fill, hold an extra request, then drain in order.
        out_ready = 1'b0;
        drive(ITYPE, 32'd1, 32'h0000_0013); step();
        chk("bp1_ready", 32'(in_ready), 32'd1);
        chk("bp1_inst",  out_inst, 32'h0010_0013);
        drive(ITYPE, 32'd2, 32'h0000_0013); step();
        chk("bp2_ready", 32'(in_ready), 32'd0);
        chk("bp2_inst",  out_inst, 32'h0010_0013);
        drive(ITYPE, 32'd3, 32'h0000_0013); step();
        chk("bp3_ready",  32'(in_ready), 32'd0);
        chk("bp3_stable", out_inst, 32'h0010_0013);
        out_ready = 1'b1; step();
        chk("bp_pop1_ready", 32'(in_ready), 32'd1);
        chk("bp_pop1_inst",  out_inst, 32'h0020_0013);
        step();
        chk("bp_pop2_valid", 32'(out_valid), 32'd1);
        chk("bp_pop2_inst",  out_inst, 32'h0030_0013);
        in_valid = 1'b0; step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Concurrent push/pop at occupancy 1 with random legal immediates.
        out_ready = 1'b0;
        drive(ITYPE, 32'd9, 32'h0000_0013); step();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            r = $urandom;
            exp_type = 3'($urandom_range(0, 4));
            case (exp_type)
                ITYPE, STYPE: exp_imm = {{20{r[11]}}, r[11:0]};
                BTYPE:        exp_imm = {{19{r[12]}}, r[12:1], 1'b0};
                UTYPE:        exp_imm = {r[31:12], 12'b0};
                default:      exp_imm = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            exp_base = $urandom;
            drive(exp_type, exp_imm, exp_base);
            step();
            chk("pp_valid", 32'(out_valid), 32'd1);
            chk("pp_ready", 32'(in_ready), 32'd1);
            chk("pp_err",   32'(out_err), 32'd0);
            chk("pp_opc",   32'(out_inst[6:0]), 32'(exp_base[6:0]));
            chk("pp_round", extend(exp_type, out_inst), exp_imm);
        end
        in_valid = 1'b0; step();
        chk("pp_empty", 32'(out_valid), 32'd0);
        chk("pp_cnt",   32'(err_cnt), 32'd4);

        // Mid-operation reset with two buffered error entries.
        out_ready = 1'b0;
        drive(UTYPE, 32'd1, 32'h0000_0037); step(); step();
        in_valid = 1'b0;
        chk("pre_rst_cnt",   32'(err_cnt),  32'd6);
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1; #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt",   32'(err_cnt),   32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_inst",  out_inst,       32'd0);
        #2 rst = 1'b0;
        drive(ITYPE, 32'd7, 32'h0000_0013); step();
        chk("post_rst_inst",  out_inst, 32'h0070_0013);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1; step();
        chk("post_rst_alone", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_pack.md
# imm_pack

Immediate packer: the encode-side counterpart of the core's immediate extender. It accepts a 32-bit immediate, an immediate type and a 32-bit instruction template, and scatters the immediate into the RV32I field positions for that type. It also checks that the immediate is representable and buffers results in a small FIFO behind a valid/ready handshake. It sits in the self-test / boot-sequence instruction generator, feeding assembled instruction words to instruction-memory write logic.

## Interface
- DEPTH, 2, result FIFO depth; power of two, ≥2
- CNT_W, 16, width of saturating error counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at clk edge
- in_imm_type  in  3  immediate type, shared codes `ITYPE/`STYPE/`BTYPE/`UTYPE/`JTYPE from Parameters.vh
- in_imm  in  32  immediate value (byte offset for B/J, full value for U)
- in_base  in  32  instruction template: opcode, rd, rs1, rs2, funct fields
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid & out_ready
- out_inst  out  32  assembled instruction
- out_err  out  1  immediate not representable for its type (or unknown type)
- err_cnt  out  CNT_W  saturating count of accepted requests with err

## Operation
- Packing overwrites only the immediate bit positions of in_base. All other bits, always including [6:0], pass through from in_base.
  - I: inst[31:20]=imm[11:0]
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]
  - U: inst[31:12]=imm[31:12]
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]
  - Other code: inst = in_base unchanged, err=1.
- Representability (err=1 if violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
- On err the packed word still uses the truncated bits per the map above; err only flags it.
- Round-trip invariant: whenever out_err=0, sign/zero-extending out_inst[31:7] by type reproduces in_imm exactly.
- The FIFO stores {inst, err}. It uses read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count 0..DEPTH.
- in_ready = (count != DEPTH), registered-state only; it has no combinational path from out_ready.
- out_valid = (count != 0). out_inst/out_err are driven from the head entry.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any count where push is permitted (count < DEPTH) and pop is permitted (count > 0).
- When full, a pop frees space, but in_ready rises only on the following cycle.
- err_cnt increments by 1 at each accepted request with err=1 and holds at 2^CNT_W−1.

## Timing
- Reset (async assert, synchronous-edge deassert use): count=0, pointers=0, err_cnt=0.
  - Resulting outputs: out_valid=0, in_ready=1, out_inst=0, out_err=0.
  - FIFO storage is cleared to 0.
- Reset mid-operation discards all buffered entries immediately; no partial result appears afterward.
- Latency: a request accepted at edge N is visible at the head with out_valid=1 after edge N (cycle N+1) when the FIFO was empty.
- Throughput: 1 request per cycle sustained while out_ready=1.
- out_inst/out_err are stable while out_valid=1 and out_ready=0.
- Packing and the range check are combinational on the inputs and registered into the FIFO. The outputs carry no combinational path from inputs.

## Test plan
- I-type, in_base=0x00000013, in_imm=0xFFFFFFFF, out_ready=1 → one cycle later out_inst=0xFFF00013, out_err=0, err_cnt=0.
- B-type, in_base=0x00000063, in_imm=0x00000800 → out_inst=0x000000E3, out_err=0. Then in_imm=0x00001000 → out_err=1, err_cnt=1.
- J-type in_imm=0x00000003 and U-type in_imm=0x00001001 → both out_err=1, err_cnt increments 2. Then S-type in_imm=0xFFFFF800, base 0x00002023 → out_inst=0x80002023, err=0.
- Backpressure: out_ready=0, push DEPTH requests → in_ready=0 after DEPTH-th accept, extra in_valid held unaccepted. Raise out_ready → entries pop in order, in_ready returns 1 cycle after first pop, no loss or duplication.
- Simultaneous push/pop at count=1 for 20 cycles with random legal immediates → count stays 1. Every output round-trips through the extender to its in_imm.
- Assert rst while FIFO holds 2 entries and err_cnt=5 → same cycle out_valid=0, err_cnt=0, in_ready=1. After release, the first new request appears alone.
